// File: rtl/mem_ctrl.sv
// Data-memory control unit: load/store responder owning a word-organised RAM.
// Sub-word stores use read-modify-write; sub-word loads are extracted and
// sign- or zero-extended. One request in flight at a time.
module mem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state | meaning
  // IDLE  | waiting for a request, req_ready high
  // LOAD  | RAM word available, format load result
  // RMW   | merge store lane(s) into the old word
  // WRITE | commit word to RAM
  // RESP  | hold response until rsp_ready
  typedef enum logic [2:0] {IDLE, LOAD, RMW, WRITE, RESP} state_t;

  state_t state, state_next;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       ram_q;
  logic [31:0]       wr_word;
  logic [ADDR_W-1:0] lat_idx;
  logic [1:0]        lat_lane;
  logic [1:0]        lat_width;
  logic              lat_uns;

  logic              accept;
  logic              req_err;
  logic              rd_en;
  logic              mem_we;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic              valid_next;
  logic              err_next;
  logic [31:0]       rdata_next;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Request legality: width, alignment and range, decided from live inputs.
  always_comb begin
    req_err = 1'b0;
    if (req_width == 2'b11) req_err = 1'b1;
    if (req_width == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_width == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (req_addr[31:ADDR_W+2] != '0) req_err = 1'b1;
  end

  // Erroneous requests never touch the RAM, not even for a read.
  assign rd_en = accept && !req_err;

  // Synchronous-read RAM; write only in WRITE. Contents are not reset.
  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[req_addr[ADDR_W+1:2]];
    if (mem_we) mem[lat_idx] <= wr_word;
  end

  // Load formatting: shift the lane down, then extend by width.
  always_comb begin
    shifted  = ram_q >> {lat_lane, 3'b000};
    load_val = ram_q;
    case (lat_width)
      2'b00:   load_val = lat_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = lat_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = ram_q;
    endcase
  end

  // Store merge: replace the addressed byte or halfword in the old word.
  always_comb begin
    merged = ram_q;
    if (lat_width == 2'b00) merged[{lat_lane, 3'b000} +: 8] = wr_word[7:0];
    else                    merged[{lat_lane[1], 4'b0000} +: 16] = wr_word[15:0];
  end

  // Request fields captured at accept; wr_word becomes the merged word in RMW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx   <= '0;
      lat_lane  <= 2'b00;
      lat_width <= 2'b00;
      lat_uns   <= 1'b0;
      wr_word   <= '0;
    end else if (accept) begin
      lat_idx   <= req_addr[ADDR_W+1:2];
      lat_lane  <= req_addr[1:0];
      lat_width <= req_width;
      lat_uns   <= req_unsigned;
      wr_word   <= req_wdata;
    end else if (state == RMW) begin
      wr_word   <= merged;
    end
  end

  // State and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= valid_next;
      rsp_err   <= err_next;
      rsp_rdata <= rdata_next;
    end
  end

  // Next-state, write strobe and next response values.
  always_comb begin
    state_next = state;
    valid_next = rsp_valid;
    err_next   = rsp_err;
    rdata_next = rsp_rdata;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
            valid_next = 1'b1;
            err_next   = 1'b1;
            rdata_next = '0;
          end else if (!req_we) begin
            state_next = LOAD;
          end else if (req_width == 2'b10) begin
            state_next = WRITE;
          end else begin
            state_next = RMW;
          end
        end
      end
      LOAD: begin
        state_next = RESP;
        valid_next = 1'b1;
        err_next   = 1'b0;
        rdata_next = load_val;
      end
      RMW: begin
        state_next = WRITE;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = RESP;
        valid_next = 1'b1;
        err_next   = 1'b0;
        rdata_next = '0;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Data-memory control unit: the responder side of the core's load/store interface. It accepts one request at a time (access width, load/store, byte address, store data), owns a word-organised data RAM, and returns a response with formatted load data or an error flag. Byte and halfword stores are done by read-modify-write; sub-word loads are extracted and sign- or zero-extended. It sits between the execute stage and the data RAM; the datapath stalls on `req_ready`/`rsp_valid`.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): word-index width (derived; do not override).
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; equals 1 exactly in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_width` in 2: 00 byte, 01 half, 10 word, 11 illegal (same encoding as funct3[1:0]).
- `req_unsigned` in 1: load zero-extends when 1 (funct3[2]); ignored for stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, low bits significant for sub-word stores.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes response.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: misaligned, out-of-range or illegal-width request.

## Operation
- States: IDLE, LOAD, RMW, WRITE, RESP.
- Handshake: request accepted on the edge where `req_valid && req_ready`. Request fields latched at accept. Inputs are ignored outside IDLE.
- Error check at accept:
  - width 11 → error;
  - half with addr[0] ≠ 0 → error;
  - word with addr[1:0] ≠ 0 → error;
  - addr ≥ DEPTH*4 → error.
- On error: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. The RAM is neither read nor written.
- Word index is addr[ADDR_W+1:2]; byte lane is addr[1:0].
- RAM has a synchronous read. The read address is driven from `req_addr` in the accept cycle.
- Load: IDLE → LOAD.
  - In LOAD, the RAM word is shifted by lane*8.
  - byte/half results are sign-extended from bit 7/15, or zero-extended if `req_unsigned`.
  - The result is registered into `rsp_rdata`, then → RESP.
- Word store: IDLE → WRITE. In WRITE, RAM[index] ← latched wdata, then → RESP.
- Sub-word store: IDLE → RMW → WRITE → RESP.
  - In RMW, register the old word with the selected lane(s) replaced: byte = wdata[7:0] at lane; half = wdata[15:0] at lanes {addr[1],0},+1.
  - In WRITE, store the merged word.
- RESP: `rsp_valid`=1 and held, with `rsp_rdata`/`rsp_err` stable, until `rsp_ready`=1. On that edge → IDLE.
- No RAM write ever occurs outside WRITE. Write-before-response ordering is guaranteed, so any request accepted after a store's response reads the new data.
- Reset mid-operation: state → IDLE immediately (asynchronous). A WRITE in progress is dropped if reset asserts before its edge. RAM contents are not reset.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
- Latency is counted from the accept edge (cycle 0) to the first cycle with `rsp_valid`=1, assuming `rsp_ready`=1:
  - error: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - byte/half store: 3 cycles.
- Minimum spacing between accepts: latency + 1 cycle, because the RESP→IDLE edge consumes one cycle.
- All outputs are registered except `req_ready`, which is a decode of the state register.
- `rsp_valid` must never drop without `rsp_ready`. `rsp_*` must not change while `rsp_valid`=1 and `rsp_ready`=0.

## Test plan
- Store word 0xDEADBEEF at addr 0x10, then load word 0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; load response 2 cycles after accept.
- After the above, store byte 0xAA at 0x11, then load word 0x10 → 0xDEADAAEF. Load byte 0x11 signed → 0xFFFFFFAA; load byte 0x11 unsigned → 0x000000AA. The byte store responds 3 cycles after accept.
- Store half 0x8001 at 0x12, then load half 0x12 signed → 0xFFFF8001; load half 0x12 unsigned → 0x00008001.
- Errors, each checked with a follow-up load of 0x10 showing RAM unchanged:
  - load word 0x13 → `rsp_err`=1, `rsp_rdata`=0, response 1 cycle after accept;
  - store half 0x11 → `rsp_err`=1;
  - width 11 → `rsp_err`=1;
  - addr DEPTH*4 → `rsp_err`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles during a load response → `rsp_valid` and `rsp_rdata` stable and `req_ready`=0 throughout; IDLE is re-entered one edge after `rsp_ready`=1.
- Reset mid-operation: assert `rst_n`=0 while in RMW of a byte store to 0x20 (old word 0x11223344) → outputs immediately return to reset values and a later load of 0x20 returns 0x11223344.
